change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vend_pkg.sv | 44 ++++
 rtl/vend_fifo.sv | 41 ++++
 rtl/change_dispenser.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types for the change dispenser: FSM states, change codes, coin values and code decode.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SODA,
    ST_DIME,
    ST_NICKEL,
    ST_GAP
  } state_e;

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_N    = 3'b001;
  localparam logic [2:0] CODE_D    = 3'b010;
  localparam logic [2:0] CODE_DN   = 3'b011;
  localparam logic [2:0] CODE_DD   = 3'b100;

  localparam int unsigned COIN_NICKEL = 5;
  localparam int unsigned COIN_DIME   = 10;

  typedef struct packed {
    logic [1:0] dimes;
    logic       nickels;
  } coins_t;

  // Illegal codes fall through to zero coins: soda only.
  function automatic coins_t decode_change(input logic [2:0] code);
    coins_t c;
    c = '0;
    case (code)
      CODE_N:  c.nickels = 1'b1;
      CODE_D:  c.dimes   = 2'd1;
      CODE_DN: begin c.dimes = 2'd1; c.nickels = 1'b1; end
      CODE_DD: c.dimes   = 2'd2;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_bad_code(input logic [2:0] code);
    return code > CODE_DD;
  endfunction

endpackage

// File: rtl/vend_fifo.sv
// Request FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module vend_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/change_dispenser.sv
// Queues vend requests and pulses soda, dime and nickel actuators in sequence with gaps.
// CHANGE_DISP_STATS_EN adds saturating vend and cents-dispensed counters.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vend_i,
  input  logic [2:0]  change_i,
  output logic        soda_motor_o,
  output logic        dime_eject_o,
  output logic        nickel_eject_o,
  output logic        busy_o,
  output logic        full_o,
  output logic        overflow_o,
  output logic        bad_code_o
`ifdef CHANGE_DISP_STATS_EN
  ,
  output logic [15:0] vend_cnt_o,
  output logic [15:0] cents_out_o
`endif
);

  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      dimes_q, dimes_d;
  logic            nickels_q, nickels_d;
  logic            soda_q, dime_q, nickel_q, busy_q, full_q, overflow_q, bad_q;
  logic            push, pop, fifo_full, fifo_empty;
  logic [2:0]      fifo_rdata;
  logic [CW-1:0]   fifo_cnt, cnt_d;
  coins_t          coins;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push  = vend_i && (!fifo_full || pop);
  assign cnt_d = fifo_cnt + CW'(push) - CW'(pop);

  vend_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (change_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dimes_d   = dimes_q;
    nickels_d = nickels_q;
    pop       = 1'b0;
    coins     = decode_change(fifo_rdata);
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        pop       = 1'b1;
        dimes_d   = coins.dimes;
        nickels_d = coins.nickels;
        state_d   = ST_SODA;
        timer_d   = PULSE_LD;
      end
      ST_SODA, ST_DIME, ST_NICKEL: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = GAP_LD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (dimes_q != 2'd0) begin
          state_d = ST_DIME;
          dimes_d = dimes_q - 2'd1;
          timer_d = PULSE_LD;
        end else if (nickels_q) begin
          state_d   = ST_NICKEL;
          nickels_d = 1'b0;
          timer_d   = PULSE_LD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so the actuator rises with the state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      dimes_q    <= '0;
      nickels_q  <= 1'b0;
      soda_q     <= 1'b0;
      dime_q     <= 1'b0;
      nickel_q   <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dimes_q    <= dimes_d;
      nickels_q  <= nickels_d;
      soda_q     <= (state_d == ST_SODA);
      dime_q     <= (state_d == ST_DIME);
      nickel_q   <= (state_d == ST_NICKEL);
      busy_q     <= (state_d != ST_IDLE) || (cnt_d != '0);
      full_q     <= (cnt_d == CW'(FIFO_DEPTH));
      overflow_q <= overflow_q | (vend_i & fifo_full & ~pop);
      bad_q      <= bad_q | (push & is_bad_code(change_i));
    end
  end

  assign soda_motor_o   = soda_q;
  assign dime_eject_o   = dime_q;
  assign nickel_eject_o = nickel_q;
  assign busy_o         = busy_q;
  assign full_o         = full_q;
  assign overflow_o     = overflow_q;
  assign bad_code_o     = bad_q;

`ifdef CHANGE_DISP_STATS_EN
  logic [15:0] vend_cnt_q, cents_q;
  logic [16:0] cents_sum;
  logic [4:0]  cents_add;

  always_comb begin
    cents_add = 5'd0;
    if (state_d == ST_DIME && state_q != ST_DIME)     cents_add = 5'(COIN_DIME);
    if (state_d == ST_NICKEL && state_q != ST_NICKEL) cents_add = 5'(COIN_NICKEL);
    cents_sum = {1'b0, cents_q} + 17'(cents_add);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vend_cnt_q <= '0;
      cents_q    <= '0;
    end else begin
      if (pop && vend_cnt_q != 16'hFFFF) vend_cnt_q <= vend_cnt_q + 16'd1;
      cents_q <= cents_sum[16] ? 16'hFFFF : cents_sum[15:0];
    end
  end

  assign vend_cnt_o  = vend_cnt_q;
  assign cents_out_o = cents_q;
`endif

endmodule
